// File: rtl/tester_pkg.sv
// Shared types for the inverter loop tester: FSM state encoding and run status codes.
package tester_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        DRIVE  = 3'd2,
        WAIT   = 3'd3,
        SETTLE = 3'd4,
        DONE   = 3'd5
    } tester_state_e;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_PASS    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_STUCK   = 2'b11;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for the asynchronous loop return; holds its contents while en_i is low.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else if (en_i) begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/inverter_loop_tester.sv
// Drives edges into the analog buffer and times their return through the synchronizer.
// Optional LOOP_SELFTEST_EN adds a bist input that loops stim_out back internally.
module inverter_loop_tester
    import tester_pkg::*;
#(
    parameter int N_EDGES     = 8,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             resp_in,
`ifdef LOOP_SELFTEST_EN
    input  logic             bist,
`endif
    output logic             stim_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] lat_last,
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max,
    output logic [CNT_W-1:0] edge_cnt,
    output tester_state_e    state_dbg
);

    localparam int SET_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] LAST_EDGE   = CNT_W'(N_EDGES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SYNC_STAGES);

    tester_state_e    state_q;
    logic             stim_q;
    logic             busy_q;
    logic             done_q;
    logic [1:0]       status_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] lat_last_q;
    logic [CNT_W-1:0] lat_min_q;
    logic [CNT_W-1:0] lat_max_q;
    logic [CNT_W-1:0] edge_cnt_q;
    logic [SET_W-1:0] settle_q;
    logic             sync_d;
    logic             resp_s;

`ifdef LOOP_SELFTEST_EN
    // One-flop internal loop so a self-test run reports SYNC_STAGES + 1 per edge.
    logic stim_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_dly_q <= 1'b0;
        end else if (ena) begin
            stim_dly_q <= stim_q;
        end
    end

    assign sync_d = bist ? stim_dly_q : resp_in;
`else
    assign sync_d = resp_in;
`endif

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk),
        .rst_ni(rst_n),
        .en_i  (ena),
        .d_i   (sync_d),
        .q_o   (resp_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            stim_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= ST_NONE;
            cnt_q      <= '0;
            lat_last_q <= '0;
            lat_min_q  <= '1;
            lat_max_q  <= '0;
            edge_cnt_q <= '0;
            settle_q   <= '0;
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lat_last_q <= '0;
                        lat_min_q  <= '1;
                        lat_max_q  <= '0;
                        edge_cnt_q <= '0;
                        done_q     <= 1'b0;
                        status_q   <= ST_NONE;
                        busy_q     <= 1'b1;
                        state_q    <= CHECK;
                    end
                end
                CHECK: begin
                    if (resp_s != stim_q) begin
                        status_q <= ST_STUCK;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    stim_q  <= ~stim_q;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (resp_s == stim_q) begin
                        lat_last_q <= cnt_q;
                        lat_min_q  <= (cnt_q < lat_min_q) ? cnt_q : lat_min_q;
                        lat_max_q  <= (cnt_q > lat_max_q) ? cnt_q : lat_max_q;
                        edge_cnt_q <= edge_cnt_q + 1'b1;
                        if (edge_cnt_q == LAST_EDGE) begin
                            status_q <= ST_PASS;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q <= DRIVE;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        status_q <= ST_TIMEOUT;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SETTLE: begin
                    // Let the forced-low stimulus drain through the loop before CHECK.
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= CHECK;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        lat_last_q <= '0;
                        lat_min_q  <= '1;
                        lat_max_q  <= '0;
                        edge_cnt_q <= '0;
                        done_q     <= 1'b0;
                        status_q   <= ST_NONE;
                        busy_q     <= 1'b1;
                        stim_q     <= 1'b0;
                        settle_q   <= '0;
                        state_q    <= SETTLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stim_out  = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign status    = status_q;
    assign lat_last  = lat_last_q;
    assign lat_min   = lat_min_q;
    assign lat_max   = lat_max_q;
    assign edge_cnt  = edge_cnt_q;
    assign state_dbg = state_q;

endmodule
